// File: rtl/cardinal_nic_dma.sv
// Transfer agent that drives a Cardinal NIC register port: sends a dmem block to the
// NIC output channel and drains NIC input packets into dmem, alternating between the two.
module cardinal_nic_dma (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        go,
  input  logic [7:0]  tx_base,
  input  logic [7:0]  tx_len,
  input  logic [7:0]  rx_base,
  input  logic [7:0]  rx_len,
  output logic        busy,
  output logic        done,
  output logic        memEn,
  output logic        memWrEn,
  output logic [7:0]  memAddr,
  output logic [63:0] mem_dout,
  input  logic [63:0] mem_din,
  output logic        nicEn,
  output logic        nicWrEn,
  output logic [1:0]  addr_nic,
  output logic [63:0] din_nic,
  input  logic [63:0] dout_nic
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_RX,
    S_POLL_TX,
    S_TX_MRD,
    S_TX_NWR,
    S_RX_NRD,
    S_RX_MWR,
    S_DONE
  } state_t;

  localparam logic [1:0] NIC_IN_BUF  = 2'b00;
  localparam logic [1:0] NIC_IN_STAT = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF = 2'b10;
  localparam logic [1:0] NIC_OUT_ST  = 2'b11;

  state_t      state, state_next;
  logic [7:0]  tx_ptr, rx_ptr;
  logic [7:0]  tx_rem, rx_rem;
  logic [63:0] rx_hold;

  logic chan_full;
  assign chan_full = dout_nic[63];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      tx_ptr  <= '0;
      rx_ptr  <= '0;
      tx_rem  <= '0;
      rx_rem  <= '0;
      rx_hold <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (go) begin
            tx_ptr <= tx_base;
            rx_ptr <= rx_base;
            tx_rem <= tx_len;
            rx_rem <= rx_len;
          end
        end
        S_TX_NWR: begin
          tx_ptr <= tx_ptr + 8'd1;
          tx_rem <= tx_rem - 8'd1;
        end
        S_RX_NRD: rx_hold <= dout_nic;
        S_RX_MWR: begin
          rx_ptr <= rx_ptr + 8'd1;
          rx_rem <= rx_rem - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output and next-state is given a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    memEn      = 1'b0;
    memWrEn    = 1'b0;
    memAddr    = '0;
    mem_dout   = '0;
    nicEn      = 1'b0;
    nicWrEn    = 1'b0;
    addr_nic   = '0;
    din_nic    = '0;

    case (state)
      S_IDLE: begin
        if (go)
          state_next = (tx_len == 8'd0 && rx_len == 8'd0) ? S_DONE : S_POLL_RX;
      end
      S_POLL_RX: begin
        nicEn    = 1'b1;
        addr_nic = NIC_IN_STAT;
        if (rx_rem != 8'd0 && chan_full)          state_next = S_RX_NRD;
        else if (tx_rem == 8'd0 && rx_rem == 8'd0) state_next = S_DONE;
        else                                       state_next = S_POLL_TX;
      end
      S_POLL_TX: begin
        nicEn    = 1'b1;
        addr_nic = NIC_OUT_ST;
        if (tx_rem != 8'd0 && !chan_full)         state_next = S_TX_MRD;
        else if (tx_rem == 8'd0 && rx_rem == 8'd0) state_next = S_DONE;
        else                                       state_next = S_POLL_RX;
      end
      S_TX_MRD: begin
        memEn      = 1'b1;
        memAddr    = tx_ptr;
        state_next = S_TX_NWR;
      end
      S_TX_NWR: begin
        nicEn      = 1'b1;
        nicWrEn    = 1'b1;
        addr_nic   = NIC_OUT_BUF;
        din_nic    = mem_din;
        state_next = S_POLL_RX;
      end
      S_RX_NRD: begin
        nicEn      = 1'b1;
        addr_nic   = NIC_IN_BUF;
        state_next = S_RX_MWR;
      end
      S_RX_MWR: begin
        memEn      = 1'b1;
        memWrEn    = 1'b1;
        memAddr    = rx_ptr;
        mem_dout   = rx_hold;
        state_next = S_POLL_TX;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // A reset arriving mid-word must not let the in-flight access reach dmem or the NIC.
    if (RESET) begin
      memEn   = 1'b0;
      memWrEn = 1'b0;
      nicEn   = 1'b0;
      nicWrEn = 1'b0;
    end
  end

endmodule

// File: tb/tb_cardinal_nic_dma.sv
// Scoreboard bench for cardinal_nic_dma: dmem and NIC models, expected writes/done
// events queued by the stimulus and popped by an independent monitor.
module tb_cardinal_nic_dma;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        go;
  logic [7:0]  tx_base, tx_len, rx_base, rx_len;
  logic        busy, done;
  logic        memEn, memWrEn;
  logic [7:0]  memAddr;
  logic [63:0] mem_dout, mem_din;
  logic        nicEn, nicWrEn;
  logic [1:0]  addr_nic;
  logic [63:0] din_nic, dout_nic;

  cardinal_nic_dma dut (
    .CLK(CLK), .RESET(RESET), .go(go),
    .tx_base(tx_base), .tx_len(tx_len), .rx_base(rx_base), .rx_len(rx_len),
    .busy(busy), .done(done),
    .memEn(memEn), .memWrEn(memWrEn), .memAddr(memAddr),
    .mem_dout(mem_dout), .mem_din(mem_din),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .addr_nic(addr_nic),
    .din_nic(din_nic), .dout_nic(dout_nic)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- dmem model ----------------
  logic [63:0] dmem [256];
  always @(posedge CLK) begin
    if (memEn && !memWrEn) mem_din <= dmem[memAddr];
    if (memEn && memWrEn)  dmem[memAddr] <= mem_dout;
  end

  // ---------------- NIC model ----------------
  logic [63:0] rx_words [16];
  int          rx_total = 0;   // written by stimulus only
  int          rx_head  = 0;   // written by NIC model only
  logic        out_full = 1'b0;
  logic        in_full;
  assign in_full = (rx_head < rx_total);

  always_comb begin
    dout_nic = '0;
    case (addr_nic)
      2'b00:   dout_nic = in_full ? rx_words[rx_head] : 64'd0;
      2'b01:   dout_nic = {in_full, 63'd0};
      2'b11:   dout_nic = {out_full, 63'd0};
      default: dout_nic = '0;
    endcase
  end

  always @(posedge CLK) begin
    if (nicEn && !nicWrEn && addr_nic == 2'b00 && in_full) rx_head <= rx_head + 1;
  end

  // ---------------- scoreboard ----------------
  typedef enum logic [1:0] {EV_NWR, EV_MWR, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  addr;
    logic [63:0] data;
  } ev_t;
  ev_t sb[$];

  function automatic void expect_ev(input ev_kind_t k, input logic [7:0] a,
                                    input logic [63:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    sb.push_back(e);
  endfunction

  task automatic pop_compare(input ev_kind_t k, input logic [7:0] a,
                             input logic [63:0] d, input string name);
    ev_t e;
    if (sb.size() == 0) begin
      check(1'b0, {name, "_unexpected"}, {56'd0, a}, 64'd0);
    end else begin
      e = sb.pop_front();
      check(e.kind == k, {name, "_kind"}, 64'(k), 64'(e.kind));
      check(e.addr == a, {name, "_addr"}, {56'd0, a}, {56'd0, e.addr});
      check(e.data == d, {name, "_data"}, d, e.data);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's state updates.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (memEn || nicEn)
        check(!(memEn && nicEn), "port_exclusive", {62'd0, memEn, nicEn}, 64'd0);
      if (nicEn && nicWrEn) begin
        check(!out_full, "nwr_while_full", 64'(out_full), 64'd0);
        check(addr_nic == 2'b10, "nwr_addr", 64'(addr_nic), 64'd2);
        pop_compare(EV_NWR, 8'd0, din_nic, "nic_write");
      end
      if (memEn && memWrEn) pop_compare(EV_MWR, memAddr, mem_dout, "mem_write");
      if (done)             pop_compare(EV_DONE, 8'd0, 64'd0, "done");
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start(input logic [7:0] tb_, input logic [7:0] tl,
                       input logic [7:0] rb, input logic [7:0] rl);
    @(negedge CLK);
    tx_base = tb_; tx_len = tl; rx_base = rb; rx_len = rl;
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check(n < 300, {name, "_timeout"}, 64'(n), 64'd300);
  endtask

  task automatic check_outputs_zero(input string name);
    check({busy, done, memEn, memWrEn, nicEn, nicWrEn, addr_nic} == 8'd0,
          {name, "_ctl"}, {56'd0, busy, done, memEn, memWrEn, nicEn, nicWrEn, addr_nic}, 64'd0);
    check(memAddr == 8'd0, {name, "_memAddr"}, {56'd0, memAddr}, 64'd0);
    check((mem_dout | din_nic) == 64'd0, {name, "_data"}, mem_dout | din_nic, 64'd0);
  endtask

  function automatic void push_rx(input logic [63:0] w);
    rx_words[rx_total] = w;
    rx_total = rx_total + 1;
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    bit seen;
    RESET = 1'b1; go = 1'b0;
    tx_base = '0; tx_len = '0; rx_base = '0; rx_len = '0;
    for (int i = 0; i < 256; i++) dmem[i] = 64'd0;
    for (int i = 0; i < 4; i++) dmem[8'h10 + i] = 64'hA5A5_0000_0000_00A0 + 64'(i);
    dmem[8'h20] = 64'hD0D0_1111_2222_33D0;
    dmem[8'h21] = 64'hD1D1_4444_5555_66D1;
    dmem[8'h30] = 64'hF0F0_0000_0000_00F0;
    dmem[8'h31] = 64'hF1F1_0000_0000_00F1;
    dmem[8'h40] = 64'hC0C0_C0C0_C0C0_C0C0;

    repeat (3) @(negedge CLK);
    check_outputs_zero("reset_state");
    RESET = 1'b0;
    @(negedge CLK);
    check_outputs_zero("idle_state");

    // Reset mid-transfer: TX_MRD is reached two cycles after the go edge.
    start(8'h10, 8'd4, 8'h00, 8'd0);
    repeat (2) @(negedge CLK);
    check(memEn == 1'b1 && memWrEn == 1'b0, "pre_reset_in_mrd", {62'd0, memEn, memWrEn}, 64'd2);
    RESET = 1'b1;
    #1;
    check({memWrEn, nicWrEn, memEn, nicEn} == 4'd0, "reset_cycle_no_access",
          {60'd0, memWrEn, nicWrEn, memEn, nicEn}, 64'd0);
    @(negedge CLK);
    check_outputs_zero("reset_mid");
    RESET = 1'b0;
    @(negedge CLK);
    check_outputs_zero("after_reset");

    // Restart from tx_base: full TX-only block, no dmem writes allowed.
    for (int i = 0; i < 4; i++) expect_ev(EV_NWR, 8'd0, 64'hA5A5_0000_0000_00A0 + 64'(i));
    expect_ev(EV_DONE, 8'd0, 64'd0);
    start(8'h10, 8'd4, 8'h00, 8'd0);
    check(busy == 1'b1, "busy_after_go", 64'(busy), 64'd1);
    wait_finish("tx_only");

    // TX backpressure: output channel full for 10 cycles.
    out_full = 1'b1;
    expect_ev(EV_NWR, 8'd0, 64'hD0D0_1111_2222_33D0);
    expect_ev(EV_NWR, 8'd0, 64'hD1D1_4444_5555_66D1);
    expect_ev(EV_DONE, 8'd0, 64'd0);
    start(8'h20, 8'd2, 8'h00, 8'd0);
    repeat (10) @(negedge CLK);
    check(busy == 1'b1, "busy_while_stalled", 64'(busy), 64'd1);
    check(sb.size() == 3, "no_write_while_full", 64'(sb.size()), 64'd3);
    out_full = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge CLK);
      if (nicEn && nicWrEn) seen = 1'b1;
    end
    check(seen, "write_within_4_after_clear", 64'(seen), 64'd1);
    wait_finish("tx_backpressure");

    // RX only with pointer wrap FE, FF, 00.
    push_rx(64'hB0B0_0000_0000_00B0);
    push_rx(64'hB1B1_0000_0000_00B1);
    push_rx(64'hB2B2_0000_0000_00B2);
    expect_ev(EV_MWR, 8'hFE, 64'hB0B0_0000_0000_00B0);
    expect_ev(EV_MWR, 8'hFF, 64'hB1B1_0000_0000_00B1);
    expect_ev(EV_MWR, 8'h00, 64'hB2B2_0000_0000_00B2);
    expect_ev(EV_DONE, 8'd0, 64'd0);
    start(8'h00, 8'd0, 8'hFE, 8'd3);
    wait_finish("rx_only");
    check(dmem[8'hFE] == 64'hB0B0_0000_0000_00B0, "dmem_FE", dmem[8'hFE], 64'hB0B0_0000_0000_00B0);
    check(dmem[8'hFF] == 64'hB1B1_0000_0000_00B1, "dmem_FF", dmem[8'hFF], 64'hB1B1_0000_0000_00B1);
    check(dmem[8'h00] == 64'hB2B2_0000_0000_00B2, "dmem_00", dmem[8'h00], 64'hB2B2_0000_0000_00B2);

    // Interleave: RX read/write then TX, strictly alternating.
    push_rx(64'hE0E0_0000_0000_00E0);
    push_rx(64'hE1E1_0000_0000_00E1);
    expect_ev(EV_MWR, 8'h80, 64'hE0E0_0000_0000_00E0);
    expect_ev(EV_NWR, 8'd0,  64'hF0F0_0000_0000_00F0);
    expect_ev(EV_MWR, 8'h81, 64'hE1E1_0000_0000_00E1);
    expect_ev(EV_NWR, 8'd0,  64'hF1F1_0000_0000_00F1);
    expect_ev(EV_DONE, 8'd0, 64'd0);
    start(8'h30, 8'd2, 8'h80, 8'd2);
    wait_finish("interleave");

    // Zero length: done and busy in the cycle right after the go edge.
    expect_ev(EV_DONE, 8'd0, 64'd0);
    start(8'h00, 8'd0, 8'h00, 8'd0);
    check(done == 1'b1, "zero_len_done", 64'(done), 64'd1);
    check(busy == 1'b1, "zero_len_busy", 64'(busy), 64'd1);
    @(negedge CLK);
    check({busy, done} == 2'b00, "zero_len_after", {62'd0, busy, done}, 64'd0);

    // go while busy must be ignored: one word, one done.
    expect_ev(EV_NWR, 8'd0, 64'hC0C0_C0C0_C0C0_C0C0);
    expect_ev(EV_DONE, 8'd0, 64'd0);
    start(8'h40, 8'd1, 8'h00, 8'd0);
    tx_base = 8'h10; tx_len = 8'd3; rx_base = 8'h90; rx_len = 8'd3;
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    wait_finish("ignored_go");
    repeat (10) @(negedge CLK);
    check(busy == 1'b0, "no_restart_after_ignored_go", 64'(busy), 64'd0);
    check(sb.size() == 0, "scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
